healthcare_alarm_sequencer: RTL and testbench

Parametrised, clocked successor to the first-phase combinational health detectors. Takes a vector of per-channel abnormality flags (pressure, blood, fall, temperature, and further channels), sampled on a strobe. An alarm is raised only after a channel stays abnormal for a configurable number of consecutive samples. Raised alarms are latched and delivered one at a time over a valid/ready handshake to the downstream notifier. A channel clears only after a configurable run of normal samples.

---
 rtl/healthcare_alarm_sequencer.sv | 139 +++++++++++++
 tb/tb_healthcare_alarm_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/healthcare_alarm_sequencer.sv
// Debounces per-channel abnormality flags into latched alarms and serialises them to a notifier.
// Latency: raise to alarmValid is 1 cycle; alarmValid/alarmCh hold under unbounded alarmReady back-pressure.
module healthcare_alarm_sequencer #(
    parameter int NUM_CH  = 4,
    parameter int PERSIST = 3,
    parameter int RECOVER = 2,
    parameter int CNT_W   = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              sampleValid,
    input  logic [NUM_CH-1:0] abnormal,
    input  logic              alarmReady,
    output logic              alarmValid,
    output logic [CH_W-1:0]   alarmCh,
    output logic [NUM_CH-1:0] alarmActive,
    output logic              anyAlarm,
    output logic [CNT_W-1:0]  eventCount
);

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_ARMING,
        CH_PENDING,
        CH_REPORTED
    } ch_state_e;

    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [3:0]        run_q   [NUM_CH];
    logic [3:0]        run_d   [NUM_CH];
    logic [NUM_CH-1:0] active_q, active_d;
    logic              vld_q, vld_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  evt_q, evt_d;
    logic              hs;
    logic              pick_vld;
    logic [CH_W-1:0]   pick;

    assign hs = vld_q && alarmReady;

    // Lowest-index PENDING channel, skipping the one already sitting in the output stage.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (state_q[i] == CH_PENDING && !(vld_q && ch_q == CH_W'(i))) begin
                pick     = CH_W'(i);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        vld_d = vld_q;
        ch_d  = ch_q;
        evt_d = evt_q;
        if (!vld_q || hs) begin
            vld_d = pick_vld;
            if (pick_vld) begin
                ch_d = pick;
            end
        end
        if (hs && evt_q != {CNT_W{1'b1}}) begin
            evt_d = evt_q + CNT_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            run_d[i]   = run_q[i];
            // A channel accepted downstream ignores the sample taken at the same edge.
            if (hs && ch_q == CH_W'(i)) begin
                state_d[i] = CH_REPORTED;
                run_d[i]   = 4'd0;
            end else if (sampleValid) begin
                case (state_q[i])
                    CH_IDLE, CH_ARMING: begin
                        if (abnormal[i]) begin
                            if (run_q[i] + 4'd1 == 4'(PERSIST)) begin
                                state_d[i] = CH_PENDING;
                                run_d[i]   = 4'd0;
                            end else begin
                                state_d[i] = CH_ARMING;
                                run_d[i]   = run_q[i] + 4'd1;
                            end
                        end else begin
                            state_d[i] = CH_IDLE;
                            run_d[i]   = 4'd0;
                        end
                    end
                    CH_REPORTED: begin
                        if (abnormal[i]) begin
                            run_d[i] = 4'd0;
                        end else if (run_q[i] + 4'd1 == 4'(RECOVER)) begin
                            state_d[i] = CH_IDLE;
                            run_d[i]   = 4'd0;
                        end else begin
                            run_d[i] = run_q[i] + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
            active_d[i] = (state_d[i] == CH_PENDING) || (state_d[i] == CH_REPORTED);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= CH_IDLE;
                run_q[i]   <= 4'd0;
            end
            active_q <= '0;
            vld_q    <= 1'b0;
            ch_q     <= '0;
            evt_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                run_q[i]   <= run_d[i];
            end
            active_q <= active_d;
            vld_q    <= vld_d;
            ch_q     <= ch_d;
            evt_q    <= evt_d;
        end
    end

    assign alarmValid  = vld_q;
    assign alarmCh     = ch_q;
    assign alarmActive = active_q;
    assign anyAlarm    = |active_q;
    assign eventCount  = evt_q;

endmodule

// File: tb/tb_healthcare_alarm_sequencer.sv
// Directed bench: main instance (PERSIST=3, RECOVER=2) plus a PERSIST=1/RECOVER=1/CNT_W=2 instance for saturation.
module tb_healthcare_alarm_sequencer;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;

    logic       sv = 1'b0, rdy = 1'b0;
    logic [3:0] abn = 4'd0;
    logic       vld, any;
    logic [1:0] ch;
    logic [3:0] act;
    logic [7:0] evt;

    logic       b_sv = 1'b0, b_rdy = 1'b0;
    logic [3:0] b_abn = 4'd0;
    logic       b_vld, b_any;
    logic [1:0] b_ch;
    logic [3:0] b_act;
    logic [1:0] b_evt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       sv;
        logic [3:0] abn;
        logic       rdy;
        logic       evld;
        logic [1:0] ech;
        logic [3:0] eact;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl [$];

    healthcare_alarm_sequencer #(.NUM_CH(4), .PERSIST(3), .RECOVER(2), .CNT_W(8)) dut (
        .clk(clk), .rstN(rstN), .sampleValid(sv), .abnormal(abn), .alarmReady(rdy),
        .alarmValid(vld), .alarmCh(ch), .alarmActive(act), .anyAlarm(any), .eventCount(evt)
    );

    healthcare_alarm_sequencer #(.NUM_CH(4), .PERSIST(1), .RECOVER(1), .CNT_W(2)) dut_b (
        .clk(clk), .rstN(rstN), .sampleValid(b_sv), .abnormal(b_abn), .alarmReady(b_rdy),
        .alarmValid(b_vld), .alarmCh(b_ch), .alarmActive(b_act), .anyAlarm(b_any), .eventCount(b_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic [3:0] a, input logic r, input logic ev,
                       input logic [1:0] ec, input logic [3:0] ea, input logic [7:0] en);
        vec_t v;
        v.sv = s; v.abn = a; v.rdy = r; v.evld = ev; v.ech = ec; v.eact = ea; v.ecnt = en;
        tbl.push_back(v);
    endtask

    initial begin
        // ch1 persistence with an interrupted run, then delivery and recovery
        add(1, 4'b0010, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b0010, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b0000, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b0010, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b0010, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b0010, 0, 0, 0, 4'b0010, 0);
        add(0, 4'b0000, 0, 1, 1, 4'b0010, 0);
        add(0, 4'b0000, 1, 0, 0, 4'b0010, 1);
        add(1, 4'b0000, 0, 0, 0, 4'b0010, 1);
        add(1, 4'b0000, 0, 0, 0, 4'b0000, 1);
        // ch0+ch2 simultaneous raise, held under back-pressure, then back-to-back
        add(1, 4'b0101, 0, 0, 0, 4'b0000, 1);
        add(1, 4'b0101, 0, 0, 0, 4'b0000, 1);
        add(1, 4'b0101, 0, 0, 0, 4'b0101, 1);
        for (int k = 0; k < 5; k++) add(0, 4'b0000, 0, 1, 0, 4'b0101, 1);
        add(0, 4'b0000, 1, 1, 2, 4'b0101, 2);
        add(0, 4'b0000, 1, 0, 0, 4'b0101, 3);
        // ch3 raise while ch0/ch2 recover; recovery run interrupted by an abnormal sample
        add(1, 4'b1000, 0, 0, 0, 4'b0101, 3);
        add(1, 4'b1000, 0, 0, 0, 4'b0000, 3);
        add(1, 4'b1000, 0, 0, 0, 4'b1000, 3);
        add(0, 4'b0000, 1, 1, 3, 4'b1000, 3);
        add(1, 4'b0000, 1, 0, 0, 4'b1000, 4);
        add(1, 4'b0000, 1, 0, 0, 4'b1000, 4);
        add(1, 4'b1000, 1, 0, 0, 4'b1000, 4);
        add(1, 4'b0000, 1, 0, 0, 4'b1000, 4);
        add(1, 4'b0000, 1, 0, 0, 4'b0000, 4);

        #12;
        chk("reset vld", vld, 0);
        chk("reset ch", ch, 0);
        chk("reset act", act, 0);
        chk("reset any", any, 0);
        chk("reset evt", evt, 0);
        chk("reset b_vld", b_vld, 0);
        chk("reset b_evt", b_evt, 0);
        rstN = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            sv = tbl[k].sv; abn = tbl[k].abn; rdy = tbl[k].rdy;
            step();
            chk($sformatf("row%0d vld", k), vld, tbl[k].evld);
            if (tbl[k].evld) chk($sformatf("row%0d ch", k), ch, tbl[k].ech);
            chk($sformatf("row%0d act", k), act, tbl[k].eact);
            chk($sformatf("row%0d any", k), any, |tbl[k].eact);
            chk($sformatf("row%0d evt", k), evt, tbl[k].ecnt);
        end

        // asynchronous reset mid-presentation with ch0 part-way armed
        sv = 1; abn = 4'b0010; rdy = 0;
        step(); step(); step();
        chk("arst setup act", act, 4'b0010);
        abn = 4'b0001;
        step(); step();
        chk("arst setup vld", vld, 1);
        chk("arst setup ch", ch, 1);
        #2 rstN = 1'b0;
        #1;
        chk("arst vld", vld, 0);
        chk("arst ch", ch, 0);
        chk("arst act", act, 0);
        chk("arst any", any, 0);
        chk("arst evt", evt, 0);
        @(posedge clk);
        #1 rstN = 1'b1;
        step();
        chk("post-arst act1", act, 0);
        step();
        chk("post-arst act2", act, 0);
        step();
        chk("post-arst act3", act, 4'b0001);

        // sampleValid low freezes channels
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        sv = 0; abn = 4'b1111; rdy = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("nosample%0d vld", k), vld, 0);
            chk($sformatf("nosample%0d act", k), act, 0);
            chk($sformatf("nosample%0d any", k), any, 0);
            chk($sformatf("nosample%0d evt", k), evt, 0);
        end
        sv = 1;
        step();
        chk("resume act1", act, 0);
        step();
        chk("resume act2", act, 0);
        step();
        chk("resume act3", act, 4'b1111);
        sv = 0;

        // PERSIST=1 immediate raise and CNT_W=2 saturation
        b_rdy = 1; b_sv = 1;
        for (int k = 0; k < 5; k++) begin
            b_abn = 4'b0001;
            step();
            chk($sformatf("sat%0d raise", k), b_act, 4'b0001);
            chk($sformatf("sat%0d any", k), b_any, 1);
            b_abn = 4'b0000;
            step();
            chk($sformatf("sat%0d vld", k), b_vld, 1);
            chk($sformatf("sat%0d ch", k), b_ch, 0);
            step();
            chk($sformatf("sat%0d evt", k), b_evt, (k + 1 > 3) ? 3 : k + 1);
            chk($sformatf("sat%0d vld_off", k), b_vld, 0);
            step();
            chk($sformatf("sat%0d clear", k), b_act, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
